dcache_resp: RTL and testbench
==============================

// Module: dcache_resp
// PURPOSE
//  Responder for the core's dcache request port. It accepts a single outstanding read or write,
//  holds it for a fixed LATENCY, then answers with a one-cycle data_valid pulse.
//  Storage is an internal byte-writable word array. It sits outside top and replaces the
//  bench-side memory model, so the pipeline's MEM-stage blocking can be exercised in RTL.
// PARAMETERS
//  ADDR_W   64   request address width
//  DATA_W   64   data width (one doubleword per array entry)
//  DEPTH    4096 array entries; power of two
//  LATENCY  2    cycles from accept to data_valid pulse; legal range 1..15
//  CTRL_W   6    ctrl_signal width, equal to the core's CTRL bus width
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous active-high reset
//  req_valid_i      in   1       request present (from dcache_req_valid_o)
//  addr_i           in   ADDR_W  byte address
//  wen_i            in   1       1 = write, 0 = read
//  wdata_i          in   DATA_W  write data, right-aligned (low bytes significant)
//  wlen_i           in   2       size: 00 = B, 01 = H, 10 = W, 11 = D
//  ctrl_signal_i    in   CTRL_W  core ctrl; the CTRL_FLUSH code cancels the pending response
//  ready_o          out  1       a request may be accepted this cycle
//  data_valid_o     out  1       one-cycle response pulse (read data or write ack)
//  data_o           out  DATA_W  aligned doubleword containing addr_i; core extracts the bytes
//  err_o            out  1       misaligned-access flag; pulses with data_valid_o
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset values: ready_o = 0, data_valid_o = 0, data_o = 0, err_o = 0, state = IDLE.
//    Array contents are not reset.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//    - IDLE: ready_o = 1. Accept occurs when req_valid_i & ready_o.
//    - On accept: latch address, wen, wdata and wlen; load cnt = LATENCY-1.
//      Go to RESP if cnt == 0, else to WAIT.
//    - WAIT: decrement cnt each cycle; go to RESP when cnt reaches 0.
//    - RESP: data_valid_o = 1 for exactly one cycle; next state is IDLE.
//    - ready_o is 0 in WAIT and RESP. Minimum initiation interval is LATENCY+1 cycles.
//  - Latency: data_valid_o rises exactly LATENCY cycles after the accept edge.
//  - Array index: addr[3+log2(DEPTH)-1:3]. Upper address bits are ignored, so addresses wrap.
//  - Write path:
//    - Commit happens on the accept edge.
//    - Byte mask = ((1 << (1 << wlen)) - 1) << addr[2:0].
//    - Data is shifted left by 8*addr[2:0].
//    - Write response: data_o = 0.
//  - Read path: the array is read at accept; data_o is held registered until RESP.
//    A read in RESP that follows a write to the same word returns the new data.
//  - Flush: CTRL_FLUSH in WAIT or RESP forces the next state to IDLE.
//    - data_valid_o is suppressed when the flush coincides with RESP.
//    - A write already committed stays committed.
//    - A request presented in the same IDLE cycle as the flush is not accepted.
//  - req_valid_i while ready_o = 0 is ignored, not queued. The initiator must hold the request.
//  - A reset mid-operation drops the pending response. Writes committed before reset remain.
// CONFIGURATION
//  - DCACHE_RESP_MISALIGN_EN defined:
//    - An access with addr[2:0] not a multiple of 2^wlen is misaligned.
//    - Misaligned write: suppressed. Misaligned read: data_o = all-ones.
//    - err_o pulses with data_valid_o. Timing is unchanged.
//  - Not defined: err_o is tied to 0. The offset is clipped to keep the mask inside one word;
//    out-of-word bytes are dropped.
// STRUCTURE
//  - Shared package xpu_mem_pkg holds:
//    - WLEN_B/H/W/D encodings
//    - CTRL_FLUSH code (shared with CTRL)
//    - typedef dresp_state_e {IDLE, WAIT, RESP}
//    - function wlen_mask(wlen, off) returning the 8-bit byte mask
//  - One sub-module, dcache_resp_sram: single-port DEPTH x DATA_W array with per-byte write
//    enable and synchronous read.
// TESTING
//  1. Reset, then write D 0x1122334455667788 @0x100, then read D @0x100
//     -> data_valid_o at accept+2; data_o = 0x1122334455667788.
//  2. Write B 0xAB @0x103 onto that word, then read @0x100
//     -> data_o = 0x11223344AB667788.
//  3. LATENCY = 1, back-to-back req_valid_i held high
//     -> accepts every 2nd cycle; each data_valid_o is one cycle wide; ready_o = 0 in RESP.
//  4. Read accepted, then CTRL_FLUSH in WAIT -> no data_valid_o; ready_o = 1 next cycle.
//     Repeat with a write -> the word is still updated.
//  5. Write W @0x102:
//     - macro on: err_o = 1 and memory unchanged;
//     - macro off: err_o = 0 and bytes 2..5 written.
//  6. Address 0x8000 with DEPTH = 4096 -> aliases index 0 (same word as 0x0).
//     rst asserted in WAIT -> all outputs 0 the next cycle; no later pulse.

Source files
------------

// File: rtl/xpu_mem_pkg.sv
// Shared memory-side definitions for the dcache responder.
//   WLEN_*      access size encodings (B/H/W/D)
//   CTRL_FLUSH  core ctrl code that cancels a pending response
//   dresp_state_e  responder FSM states
//   wlen_mask() byte-enable mask for a size at a byte offset (out-of-word bytes dropped)
//   misaligned() true when the offset is not a multiple of the access size
package xpu_mem_pkg;

    localparam logic [1:0] WLEN_B = 2'b00;
    localparam logic [1:0] WLEN_H = 2'b01;
    localparam logic [1:0] WLEN_W = 2'b10;
    localparam logic [1:0] WLEN_D = 2'b11;

    localparam logic [5:0] CTRL_FLUSH = 6'h3f;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_e;

    // ((1 << (1 << wlen)) - 1) << off, truncated to one doubleword
    function automatic logic [7:0] wlen_mask(input logic [1:0] wlen, input logic [2:0] off);
        logic [7:0] size_mask;
        unique case (wlen)
            WLEN_B:  size_mask = 8'h01;
            WLEN_H:  size_mask = 8'h03;
            WLEN_W:  size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
        return size_mask << off;
    endfunction

    function automatic logic misaligned(input logic [1:0] wlen, input logic [2:0] off);
        logic [2:0] keep;
        keep = 3'b111 << wlen;
        return (off & ~keep) != 3'b000;
    endfunction

endpackage

// File: rtl/dcache_resp_if.sv
// Request/response bundle between the core's dcache port and dcache_resp.
//   master: core side (drives request, ctrl); slave: responder side.
interface dcache_resp_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 6
) ();
    logic              req_valid_i;
    logic [ADDR_W-1:0] addr_i;
    logic              wen_i;
    logic [DATA_W-1:0] wdata_i;
    logic [1:0]        wlen_i;
    logic [CTRL_W-1:0] ctrl_signal_i;
    logic              ready_o;
    logic              data_valid_o;
    logic [DATA_W-1:0] data_o;
    logic              err_o;

    modport master (
        output req_valid_i, addr_i, wen_i, wdata_i, wlen_i, ctrl_signal_i,
        input  ready_o, data_valid_o, data_o, err_o
    );

    modport slave (
        input  req_valid_i, addr_i, wen_i, wdata_i, wlen_i, ctrl_signal_i,
        output ready_o, data_valid_o, data_o, err_o
    );
endinterface

// File: rtl/dcache_resp_sram.sv
// Single-port DEPTH x DATA_W array, per-byte write enable, synchronous read.
//   clk   clock
//   en    access strobe; we selects write (1) or read (0)
//   idx   word index
//   be    byte enables for writes
//   wdata write data (already lane-aligned)
//   rdata registered read data, held until the next read
module dcache_resp_sram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    parameter int unsigned NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [NB-1:0]     be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end
endmodule

// File: rtl/dcache_resp.sv
// dcache request responder: one outstanding access, fixed LATENCY, one-cycle data_valid pulse.
//   clk, rst   clock, synchronous active-high reset
//   bus        dcache_resp_if.slave: req_valid/addr/wen/wdata/wlen/ctrl_signal in,
//              ready/data_valid/data/err out
// Optional feature: DCACHE_RESP_MISALIGN_EN -- misaligned writes are dropped, misaligned reads
// return all-ones, err_o flags both. Without it err_o is 0 and out-of-word bytes are dropped.
module dcache_resp
    import xpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CTRL_W  = 6
) (
    input  logic          clk,
    input  logic          rst,
    dcache_resp_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned NB     = DATA_W / 8;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    dresp_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q;
    logic              wen_q;
    logic              err_q;
    logic              flush;
    logic              accept;
    logic              mis;
    logic [2:0]        off;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata;
    logic              sram_en;
    logic              sram_we;

    // Upper address bits are ignored on purpose: addresses alias modulo DEPTH words.
    logic unused_addr;
    assign unused_addr = ^bus.addr_i[ADDR_W-1:3+IDX_W];

    assign flush    = bus.ctrl_signal_i == CTRL_W'(CTRL_FLUSH);
    assign accept   = bus.req_valid_i & ready_q & ~flush & (state_q == IDLE);
    assign off      = bus.addr_i[2:0];
    assign be       = NB'(wlen_mask(bus.wlen_i, off));
    assign wdata_sh = bus.wdata_i << {off, 3'b000};

`ifdef DCACHE_RESP_MISALIGN_EN
    assign mis = misaligned(bus.wlen_i, off);
`else
    assign mis = 1'b0;
`endif

    // Writes commit on the accept edge; a suppressed write must not disturb rdata either.
    assign sram_en = accept & ~(bus.wen_i & mis);
    assign sram_we = bus.wen_i;

    dcache_resp_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .idx   (bus.addr_i[3 +: IDX_W]),
        .be    (be),
        .wdata (wdata_sh),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Registered so ready stays low through the reset cycle
            ready_q <= (state_d == IDLE);
            if (accept) begin
                wen_q <= bus.wen_i;
                err_q <= mis;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = LAT_M1;
                    state_d = (LAT_M1 == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
                if (flush)         state_d = IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o      = ready_q;
        bus.data_valid_o = (state_q == RESP) & ~flush;
        bus.err_o        = bus.data_valid_o & err_q;
        bus.data_o       = '0;
        if (state_q == RESP && !wen_q) bus.data_o = err_q ? '1 : rdata;
    end
endmodule

// File: tb/tb_dcache_resp.sv
module tb_dcache_resp;
    import xpu_mem_pkg::*;

`ifdef DCACHE_RESP_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_resp_if bus0 ();
    dcache_resp_if bus1 ();

    dcache_resp #(.LATENCY(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dcache_resp #(.LATENCY(1), .DEPTH(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int tests = 0;
    int fails = 0;

    // Reference memory: word index -> doubleword
    logic [63:0] model [int];

    function automatic int widx(input logic [63:0] a);
        return int'(a[14:3]);
    endfunction

    function automatic bit is_mis(input logic [1:0] wl, input logic [63:0] a);
        int sz;
        sz = 1 << wl;
        return MIS_EN && ((int'(a[2:0]) % sz) != 0);
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        if (model.exists(widx(a))) return model[widx(a)];
        return 'x;
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] wd,
                                        input logic [1:0] wl);
        logic [63:0] w;
        int off, sz;
        if (is_mis(wl, a)) return;
        w   = model_read(a);
        off = int'(a[2:0]);
        sz  = 1 << wl;
        for (int i = 0; i < sz; i++) begin
            if (off + i < 8) w[8*(off+i) +: 8] = wd[8*i +: 8];
        end
        model[widx(a)] = w;
    endfunction

    // Present a request on bus0 and hold it until accepted; returns at the negedge after
    // the accept edge with req_valid dropped. ok = 0 if never accepted.
    task automatic start_req(input bit wen, input logic [63:0] a, input logic [63:0] wd,
                             input logic [1:0] wl, output bit ok);
        int n;
        @(negedge clk);
        bus0.req_valid_i = 1'b1;
        bus0.wen_i       = wen;
        bus0.addr_i      = a;
        bus0.wdata_i     = wd;
        bus0.wlen_i      = wl;
        n = 0;
        while (bus0.ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 20);
        @(negedge clk);
        bus0.req_valid_i = 1'b0;
    endtask

    // Full access on bus0: lat = cycles from accept edge to data_valid (-1 on timeout),
    // wide = data_valid still high one cycle later.
    task automatic access(input bit wen, input logic [63:0] a, input logic [63:0] wd,
                          input logic [1:0] wl, output logic [63:0] rd, output logic er,
                          output int lat, output bit wide);
        bit ok;
        int n;
        start_req(wen, a, wd, wl, ok);
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        wide = 1'b0;
        if (!ok) return;
        n = 1;
        while (n <= 20) begin
            if (bus0.data_valid_o === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (lat < 0) return;
        rd = bus0.data_o;
        er = bus0.err_o;
        @(negedge clk);
        wide = (bus0.data_valid_o !== 1'b0);
    endtask

    task automatic test_reset();
        bus0.req_valid_i = 0; bus0.addr_i = 0; bus0.wen_i = 0; bus0.wdata_i = 0;
        bus0.wlen_i = 0; bus0.ctrl_signal_i = 0;
        bus1.req_valid_i = 0; bus1.addr_i = 0; bus1.wen_i = 0; bus1.wdata_i = 0;
        bus1.wlen_i = 0; bus1.ctrl_signal_i = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus0.ready_o, bus0.data_valid_o, bus0.err_o} !== 3'b000 || bus0.data_o !== 64'd0) begin
            $display("FAIL reset_outputs: got rdy=%b dv=%b err=%b data=%h, required all 0",
                     bus0.ready_o, bus0.data_valid_o, bus0.err_o, bus0.data_o);
            fails++;
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus0.ready_o !== 1'b1 || bus1.ready_o !== 1'b1) begin
            $display("FAIL ready_after_reset: got %b/%b required 1/1", bus0.ready_o, bus1.ready_o);
            fails++;
        end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat; bit wide;
        access(1, 64'h100, 64'h1122334455667788, WLEN_D, rd, er, lat, wide);
        model_write(64'h100, 64'h1122334455667788, WLEN_D);
        tests++;
        if (lat != 2 || rd !== 64'd0 || wide) begin
            $display("FAIL write_d_resp: got lat=%0d data=%h wide=%b required 2/0/0", lat, rd, wide);
            fails++;
        end
        access(0, 64'h100, 64'h0, WLEN_D, rd, er, lat, wide);
        tests++;
        if (lat != 2 || rd !== 64'h1122334455667788 || er !== 1'b0) begin
            $display("FAIL read_d: got lat=%0d data=%h err=%b required 2/1122334455667788/0",
                     lat, rd, er);
            fails++;
        end
        // Byte write onto the same word
        access(1, 64'h103, 64'hab, WLEN_B, rd, er, lat, wide);
        model_write(64'h103, 64'hab, WLEN_B);
        access(0, 64'h100, 64'h0, WLEN_D, rd, er, lat, wide);
        tests++;
        if (rd !== 64'h11223344ab667788) begin
            $display("FAIL byte_merge: got %h required 11223344ab667788", rd);
            fails++;
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, a, wd, exp_d; logic er; int lat; bit wide;
        logic [1:0] wl; bit wr;
        for (int i = 0; i < 8; i++) begin
            a  = (64'($urandom) << 15) | (64'h200 + 64'(8 * i));
            wd = {$urandom, $urandom};
            access(1, a, wd, WLEN_D, rd, er, lat, wide);
            model_write(a, wd, WLEN_D);
        end
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom_range(0, 1));
            wl = 2'($urandom_range(0, 3));
            a  = (64'($urandom) << 15) | 64'h200 | (64'($urandom_range(0, 7)) << 3)
                 | 64'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            access(wr, a, wd, wl, rd, er, lat, wide);
            if (wr) begin
                exp_d = 64'd0;
                model_write(a, wd, wl);
            end else begin
                exp_d = is_mis(wl, a) ? '1 : model_read(a);
            end
            tests++;
            if (lat != 2 || wide || rd !== exp_d || er !== is_mis(wl, a)) begin
                $display("FAIL random[%0d] wr=%b wl=%0d a=%h: got lat=%0d wide=%b data=%h err=%b required 2/0/%h/%b",
                         n, wr, wl, a, lat, wide, rd, er, exp_d, is_mis(wl, a));
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        n = 0;
        while (bus1.ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus1.wen_i = 1'b0; bus1.addr_i = 64'h0; bus1.wlen_i = WLEN_D;
        bus1.req_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (bus1.ready_o !== (i % 2 == 0) || bus1.data_valid_o !== (i % 2 == 1)) begin
                $display("FAIL b2b[%0d]: got rdy=%b dv=%b required %b/%b",
                         i, bus1.ready_o, bus1.data_valid_o, i % 2 == 0, i % 2 == 1);
                fails++;
            end
            @(negedge clk);
        end
        bus1.req_valid_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [63:0] rd; logic er; int lat; bit wide, ok, seen;
        access(1, 64'h300, 64'h0123456789abcdef, WLEN_D, rd, er, lat, wide);
        model_write(64'h300, 64'h0123456789abcdef, WLEN_D);
        // Read flushed in WAIT
        start_req(0, 64'h300, 0, WLEN_D, ok);
        bus0.ctrl_signal_i = CTRL_FLUSH;
        @(negedge clk);
        bus0.ctrl_signal_i = '0;
        tests++;
        if (!ok || bus0.ready_o !== 1'b1 || bus0.data_valid_o !== 1'b0) begin
            $display("FAIL flush_wait_read: got ok=%b rdy=%b dv=%b required 1/1/0",
                     ok, bus0.ready_o, bus0.data_valid_o);
            fails++;
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus0.data_valid_o !== 1'b0) seen = 1;
        end
        tests++;
        if (seen) begin
            $display("FAIL flush_no_pulse: got a data_valid pulse, required none");
            fails++;
        end
        // Write flushed in WAIT stays committed
        start_req(1, 64'h300, 64'hcafef00ddeadbeef, WLEN_D, ok);
        model_write(64'h300, 64'hcafef00ddeadbeef, WLEN_D);
        bus0.ctrl_signal_i = CTRL_FLUSH;
        @(negedge clk);
        bus0.ctrl_signal_i = '0;
        access(0, 64'h300, 0, WLEN_D, rd, er, lat, wide);
        tests++;
        if (rd !== model_read(64'h300)) begin
            $display("FAIL flush_write_kept: got %h required %h", rd, model_read(64'h300));
            fails++;
        end
        // Flush coinciding with RESP
        start_req(0, 64'h300, 0, WLEN_D, ok);
        @(negedge clk);
        bus0.ctrl_signal_i = CTRL_FLUSH;
        #1;
        tests++;
        if (bus0.data_valid_o !== 1'b0) begin
            $display("FAIL flush_resp: got dv=%b required 0", bus0.data_valid_o);
            fails++;
        end
        @(negedge clk);
        // Request presented with flush in IDLE is not accepted
        bus0.req_valid_i = 1'b1;
        @(negedge clk);
        tests++;
        if (bus0.ready_o !== 1'b1 || bus0.data_valid_o !== 1'b0) begin
            $display("FAIL flush_idle_req: got rdy=%b dv=%b required 1/0",
                     bus0.ready_o, bus0.data_valid_o);
            fails++;
        end
        bus0.req_valid_i = 1'b0;
        bus0.ctrl_signal_i = '0;
    endtask

    task automatic test_misalign();
        logic [63:0] rd, exp_d; logic er; int lat; bit wide;
        access(1, 64'h400, 64'h0, WLEN_D, rd, er, lat, wide);
        model_write(64'h400, 64'h0, WLEN_D);
        access(1, 64'h402, 64'hdeadbeef, WLEN_W, rd, er, lat, wide);
        tests++;
        if (er !== MIS_EN || lat != 2) begin
            $display("FAIL misalign_err: got err=%b lat=%0d required %b/2", er, lat, MIS_EN);
            fails++;
        end
        access(0, 64'h400, 0, WLEN_D, rd, er, lat, wide);
        exp_d = MIS_EN ? 64'h0 : 64'h0000deadbeef0000;
        model_write(64'h402, 64'hdeadbeef, WLEN_W);
        tests++;
        if (rd !== exp_d) begin
            $display("FAIL misalign_mem: got %h required %h", rd, exp_d);
            fails++;
        end
    endtask

    task automatic test_alias_reset();
        logic [63:0] rd; logic er; int lat; bit wide, ok, seen;
        access(1, 64'h0, 64'h1111111111111111, WLEN_D, rd, er, lat, wide);
        access(1, 64'h8000, 64'h2222222222222222, WLEN_D, rd, er, lat, wide);
        access(0, 64'h0, 0, WLEN_D, rd, er, lat, wide);
        tests++;
        if (rd !== 64'h2222222222222222) begin
            $display("FAIL alias: got %h required 2222222222222222", rd);
            fails++;
        end
        start_req(0, 64'h0, 0, WLEN_D, ok);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus0.ready_o, bus0.data_valid_o, bus0.err_o} !== 3'b000 || bus0.data_o !== 64'd0) begin
            $display("FAIL reset_in_wait: got rdy=%b dv=%b err=%b data=%h, required all 0",
                     bus0.ready_o, bus0.data_valid_o, bus0.err_o, bus0.data_o);
            fails++;
        end
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus0.data_valid_o !== 1'b0) seen = 1;
        end
        tests++;
        if (seen || bus0.ready_o !== 1'b1) begin
            $display("FAIL reset_drops_resp: got pulse=%b rdy=%b required 0/1", seen, bus0.ready_o);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_random();
        test_back_to_back();
        test_flush();
        test_misalign();
        test_alias_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
